// File: rtl/vga_sprite_regs.sv
// CPU sprite shadow registers committed atomically to the active outputs at frame end.
// Reads: 1 clk registered latency. No backpressure: CPU accesses always complete; vga_ack held until vga_int drops.
module vga_sprite_regs #(
   parameter logic [15:0] BASE_ADDR = 16'hF000,
   parameter logic [15:0] SHIP_X0   = 16'd312,
   parameter logic [15:0] SHIP_Y0   = 16'd440,
   parameter logic [15:0] PLANET_X0 = 16'd312,
   parameter logic [15:0] PLANET_Y0 = 16'd16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_din,
   input  logic        cpu_we,
   input  logic        cpu_re,
   output logic [15:0] cpu_dout,
   output logic        cpu_irq,
   input  logic        vga_int,
   output logic        vga_ack,
   output logic [15:0] spaceship_x,
   output logic [15:0] spaceship_y,
   output logic [15:0] spaceship_bitmap [16],
   output logic [15:0] planet_x,
   output logic [15:0] planet_y,
   output logic [15:0] planet_bitmap [16]
);

   typedef enum logic [1:0] {IDLE, SERVICE, ACK_HOLD, ACK} state_t;

   state_t      state, state_nxt;
   logic        service;
   logic        in_win, wr, rd, ctrl_set, ctrl_rd;
   logic [5:0]  off;
   logic [15:0] rd_dat;
   logic [15:0] sh_pos [4];
   logic [15:0] sh_ship_bm [16];
   logic [15:0] sh_planet_bm [16];
   logic        commit_req, frame_pending;
   logic [15:0] frame_count;

   assign in_win   = (cpu_addr[15:6] == BASE_ADDR[15:6]);
   assign off      = cpu_addr[5:0];
   assign wr       = cpu_we && in_win;
   assign rd       = cpu_re && in_win;
   assign ctrl_set = wr && (off == 6'h04) && cpu_din[0];
   assign ctrl_rd  = rd && (off == 6'h04);
   assign cpu_irq  = frame_pending;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // ACK_HOLD guarantees two clocks of vga_ack even if vga_int drops early
   always_comb begin
      state_nxt = state;
      vga_ack   = 1'b0;
      service   = 1'b0;
      case (state)
         IDLE:     if (vga_int) state_nxt = SERVICE;
         SERVICE:  begin service = 1'b1; state_nxt = ACK_HOLD; end
         ACK_HOLD: begin vga_ack = 1'b1; state_nxt = ACK; end
         ACK:      begin vga_ack = 1'b1; if (!vga_int) state_nxt = IDLE; end
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_pos[0] <= SHIP_X0;
         sh_pos[1] <= SHIP_Y0;
         sh_pos[2] <= PLANET_X0;
         sh_pos[3] <= PLANET_Y0;
         for (int i = 0; i < 16; i++) begin
            sh_ship_bm[i]   <= '0;
            sh_planet_bm[i] <= '0;
         end
      end else if (wr) begin
         if (off[5:2] == 4'b0000) sh_pos[off[1:0]]      <= cpu_din;
         if (off[5:4] == 2'b01)   sh_ship_bm[off[3:0]]   <= cpu_din;
         if (off[5:4] == 2'b10)   sh_planet_bm[off[3:0]] <= cpu_din;
      end
   end

   // Active outputs only move in the SERVICE clock, so the display never tears
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spaceship_x <= SHIP_X0;
         spaceship_y <= SHIP_Y0;
         planet_x    <= PLANET_X0;
         planet_y    <= PLANET_Y0;
         for (int i = 0; i < 16; i++) begin
            spaceship_bitmap[i] <= '0;
            planet_bitmap[i]    <= '0;
         end
      end else if (service && commit_req) begin
         spaceship_x <= sh_pos[0];
         spaceship_y <= sh_pos[1];
         planet_x    <= sh_pos[2];
         planet_y    <= sh_pos[3];
         for (int i = 0; i < 16; i++) begin
            spaceship_bitmap[i] <= sh_ship_bm[i];
            planet_bitmap[i]    <= sh_planet_bm[i];
         end
      end
   end

   // Sets take priority over clears when both land in the same clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         commit_req    <= 1'b0;
         frame_pending <= 1'b0;
         frame_count   <= '0;
      end else begin
         commit_req    <= (commit_req && !service) || ctrl_set;
         frame_pending <= (frame_pending && !ctrl_rd) || service;
         if (service) frame_count <= frame_count + 16'd1;
      end
   end

   always_comb begin
      rd_dat = '0;
      if (in_win) begin
         if (off[5:2] == 4'b0000)    rd_dat = sh_pos[off[1:0]];
         else if (off == 6'h04)      rd_dat = {14'b0, commit_req, frame_pending};
         else if (off == 6'h05)      rd_dat = frame_count;
         else if (off[5:4] == 2'b01) rd_dat = sh_ship_bm[off[3:0]];
         else if (off[5:4] == 2'b10) rd_dat = sh_planet_bm[off[3:0]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         cpu_dout <= '0;
      else if (cpu_re) cpu_dout <= rd_dat;
   end

endmodule

// File: tb/tb_vga_sprite_regs.sv
// Randomised bench for vga_sprite_regs against an offset-indexed register model.
// Drives and samples on the falling edge; DUT acts on the rising edge.
module tb_vga_sprite_regs;
   localparam logic [15:0] BASE = 16'hF000;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_addr, cpu_din, cpu_dout;
   logic        cpu_we, cpu_re, cpu_irq, vga_int, vga_ack;
   logic [15:0] spaceship_x, spaceship_y, planet_x, planet_y;
   logic [15:0] spaceship_bitmap [16];
   logic [15:0] planet_bitmap [16];

   int checks = 0;
   int errors = 0;

   // Model: shadow and active images indexed by register offset
   logic [15:0] sh  [64];
   logic [15:0] act [64];
   bit          m_commit, m_pend;
   logic [15:0] m_fcnt;

   vga_sprite_regs #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_re(cpu_re),
      .cpu_dout(cpu_dout), .cpu_irq(cpu_irq),
      .vga_int(vga_int), .vga_ack(vga_ack),
      .spaceship_x(spaceship_x), .spaceship_y(spaceship_y), .spaceship_bitmap(spaceship_bitmap),
      .planet_x(planet_x), .planet_y(planet_y), .planet_bitmap(planet_bitmap)
   );

   always #5 clk = ~clk;

   function automatic bit is_shadow(int o);
      return (o < 4) || (o >= 16 && o < 48);
   endfunction

   function automatic void m_reset();
      for (int o = 0; o < 64; o++) sh[o] = 16'h0;
      sh[0] = 16'd312; sh[1] = 16'd440; sh[2] = 16'd312; sh[3] = 16'd16;
      act = sh;
      m_commit = 0; m_pend = 0; m_fcnt = 16'h0;
   endfunction

   function automatic void m_frame();
      if (m_commit) act = sh;
      m_commit = 0;
      m_pend = 1;
      m_fcnt = m_fcnt + 16'd1;
   endfunction

   function automatic void m_write(logic [15:0] a, logic [15:0] d);
      int o;
      if ((a >> 6) != (BASE >> 6)) return;
      o = int'(a % 64);
      if (is_shadow(o)) sh[o] = d;
      else if (o == 4 && d[0]) m_commit = 1;
   endfunction

   function automatic logic [15:0] m_read(logic [15:0] a);
      int o;
      logic [15:0] v;
      if ((a >> 6) != (BASE >> 6)) return 16'h0;
      o = int'(a % 64);
      if (is_shadow(o)) return sh[o];
      if (o == 5) return m_fcnt;
      if (o != 4) return 16'h0;
      v = 16'(m_commit) * 16'd2 + 16'(m_pend);
      m_pend = 0;
      return v;
   endfunction

   function automatic int act_mismatches();
      int n = 0;
      if (spaceship_x !== act[0]) n++;
      if (spaceship_y !== act[1]) n++;
      if (planet_x !== act[2]) n++;
      if (planet_y !== act[3]) n++;
      for (int r = 0; r < 16; r++) begin
         if (spaceship_bitmap[r] !== act[16 + r]) n++;
         if (planet_bitmap[r] !== act[32 + r]) n++;
      end
      return n;
   endfunction

   function automatic logic [15:0] rand_addr();
      logic [15:0] a;
      if ($urandom_range(0, 7) == 0) begin
         a = 16'($urandom);
         if (a[15:6] == BASE[15:6]) a[15] = ~a[15];
      end else begin
         a = {BASE[15:6], 6'($urandom_range(0, 63))};
      end
      return a;
   endfunction

   task automatic do_write(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      cpu_addr = a; cpu_din = d; cpu_we = 1'b1;
      @(negedge clk);
      cpu_we = 1'b0;
      m_write(a, d);
   endtask

   task automatic do_read(input logic [15:0] a, output logic [15:0] d, output logic [15:0] exp);
      @(negedge clk);
      cpu_addr = a; cpu_re = 1'b1;
      exp = m_read(a);
      @(negedge clk);
      cpu_re = 1'b0;
      d = cpu_dout;
   endtask

   task automatic do_rw(input logic [15:0] a, input logic [15:0] wd,
                        output logic [15:0] d, output logic [15:0] exp);
      @(negedge clk);
      cpu_addr = a; cpu_din = wd; cpu_we = 1'b1; cpu_re = 1'b1;
      exp = m_read(a);
      m_write(a, wd);
      @(negedge clk);
      cpu_we = 1'b0; cpu_re = 1'b0;
      d = cpu_dout;
   endtask

   task automatic wait_ack(input logic level);
      int n = 0;
      while (vga_ack !== level && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (vga_ack !== level) begin
         errors++;
         $display("FAIL ack_wait: vga_ack=%b expected %b within 20 clk", vga_ack, level);
      end
   endtask

   task automatic run_frame();
      @(negedge clk);
      vga_int = 1'b1;
      wait_ack(1'b1);
      vga_int = 1'b0;
      wait_ack(1'b0);
      m_frame();
   endtask

   task automatic test_reset();
      checks += 8;
      if (spaceship_x !== 16'd312) begin errors++; $display("FAIL rst_ship_x: got %0d expected 312", spaceship_x); end
      if (spaceship_y !== 16'd440) begin errors++; $display("FAIL rst_ship_y: got %0d expected 440", spaceship_y); end
      if (planet_x !== 16'd312) begin errors++; $display("FAIL rst_planet_x: got %0d expected 312", planet_x); end
      if (planet_y !== 16'd16) begin errors++; $display("FAIL rst_planet_y: got %0d expected 16", planet_y); end
      if (act_mismatches() != 0) begin errors++; $display("FAIL rst_active: %0d fields differ expected 0", act_mismatches()); end
      if (vga_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", vga_ack); end
      if (cpu_irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", cpu_irq); end
      if (cpu_dout !== 16'h0) begin errors++; $display("FAIL rst_dout: got %h expected 0000", cpu_dout); end
   endtask

   task automatic test_no_commit();
      logic [15:0] d, e;
      do_write(BASE + 16'h00, 16'd100);
      do_write(BASE + 16'h13, 16'hF0F0);
      run_frame();
      checks += 4;
      if (spaceship_x !== 16'd312) begin errors++; $display("FAIL nocommit_x: got %0d expected 312", spaceship_x); end
      if (spaceship_bitmap[3] !== 16'h0) begin errors++; $display("FAIL nocommit_row3: got %h expected 0000", spaceship_bitmap[3]); end
      do_read(BASE + 16'h05, d, e);
      if (d !== 16'd1 || d !== e) begin errors++; $display("FAIL nocommit_fcnt: got %0d expected 1", d); end
      do_read(BASE + 16'h00, d, e);
      if (d !== 16'd100) begin errors++; $display("FAIL nocommit_readback: got %0d expected 100", d); end
   endtask

   task automatic test_commit();
      logic [15:0] d, e;
      int hi;
      do_write(BASE + 16'h04, 16'h0001);
      @(negedge clk);
      vga_int = 1'b1;
      @(negedge clk);
      checks += 4;
      if (spaceship_x !== 16'd312 || vga_ack !== 1'b0) begin
         errors++; $display("FAIL commit_early: x=%0d ack=%b expected 312/0 in SERVICE clk", spaceship_x, vga_ack);
      end
      @(negedge clk);
      m_frame();
      if (spaceship_x !== 16'd100 || vga_ack !== 1'b1) begin
         errors++; $display("FAIL commit_timing: x=%0d ack=%b expected 100/1", spaceship_x, vga_ack);
      end
      if (act_mismatches() != 0 || spaceship_bitmap[3] !== 16'hF0F0) begin
         errors++; $display("FAIL commit_image: %0d fields differ, row3=%h expected F0F0", act_mismatches(), spaceship_bitmap[3]);
      end
      vga_int = 1'b0;
      hi = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (vga_ack) hi++;
         else break;
      end
      if (hi < 2 || hi > 3 || vga_ack !== 1'b0) begin
         errors++; $display("FAIL ack_width: high %0d clk, ack=%b expected 2..3 then 0", hi, vga_ack);
      end
      do_read(BASE + 16'h04, d, e);
      checks++;
      if (d !== e || d[1] !== 1'b0) begin errors++; $display("FAIL commit_ctrl: got %h expected %h", d, e); end
   endtask

   task automatic test_service_collision();
      logic [15:0] d, e;
      do_write(BASE + 16'h00, 16'd150);
      do_write(BASE + 16'h04, 16'h0001);
      @(negedge clk);
      vga_int = 1'b1;
      @(negedge clk);
      cpu_addr = BASE; cpu_din = 16'd200; cpu_we = 1'b1;
      @(negedge clk);
      cpu_we = 1'b0;
      m_frame();
      m_write(BASE, 16'd200);
      checks++;
      if (spaceship_x !== 16'd150 || spaceship_x !== act[0]) begin
         errors++; $display("FAIL coll_write: x=%0d expected 150", spaceship_x);
      end
      vga_int = 1'b0;
      wait_ack(1'b0);
      do_read(BASE, d, e);
      checks++;
      if (d !== 16'd200) begin errors++; $display("FAIL coll_shadow: got %0d expected 200", d); end
      do_read(BASE + 16'h04, d, e);
      checks++;
      if (d !== e) begin errors++; $display("FAIL coll_ctrl1: got %h expected %h", d, e); end
      // CTRL commit write plus CTRL read landing in the SERVICE clock
      @(negedge clk);
      vga_int = 1'b1;
      @(negedge clk);
      cpu_addr = BASE + 16'h04; cpu_din = 16'h0001; cpu_we = 1'b1; cpu_re = 1'b1;
      e = m_read(BASE + 16'h04);
      m_frame();
      m_write(BASE + 16'h04, 16'h0001);
      @(negedge clk);
      cpu_we = 1'b0; cpu_re = 1'b0;
      checks += 2;
      if (cpu_dout !== e || cpu_dout !== 16'h0) begin errors++; $display("FAIL coll_ctrl_read: got %h expected 0000", cpu_dout); end
      if (spaceship_x !== 16'd150) begin errors++; $display("FAIL coll_prior_commit: x=%0d expected 150", spaceship_x); end
      vga_int = 1'b0;
      wait_ack(1'b0);
      do_read(BASE + 16'h04, d, e);
      checks++;
      if (d !== e || d !== 16'h0003) begin errors++; $display("FAIL coll_ctrl2: got %h expected 0003", d); end
      run_frame();
      checks++;
      if (spaceship_x !== 16'd200 || act_mismatches() != 0) begin
         errors++; $display("FAIL coll_next_frame: x=%0d expected 200", spaceship_x);
      end
   endtask

   task automatic test_irq();
      logic [15:0] d, e, held;
      run_frame();
      checks += 5;
      if (cpu_irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", cpu_irq); end
      do_read(BASE + 16'h04, d, e);
      if (d !== e || d[0] !== 1'b1) begin errors++; $display("FAIL irq_read1: got %h expected %h", d, e); end
      if (cpu_irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", cpu_irq); end
      held = d;
      repeat (3) @(negedge clk);
      if (cpu_dout !== held) begin errors++; $display("FAIL dout_hold: got %h expected %h", cpu_dout, held); end
      do_read(BASE + 16'h04, d, e);
      if (d !== e || d[0] !== 1'b0) begin errors++; $display("FAIL irq_read2: got %h expected %h", d, e); end
      repeat (20) run_frame();
      do_read(BASE + 16'h05, d, e);
      checks++;
      if (d !== e) begin errors++; $display("FAIL fcnt: got %0d expected %0d", d, e); end
   endtask

   task automatic test_unmapped();
      logic [15:0] addrs [5];
      logic [15:0] d, e;
      addrs[0] = BASE + 16'h06; addrs[1] = BASE + 16'h30; addrs[2] = BASE + 16'd64;
      addrs[3] = BASE + 16'h3F; addrs[4] = 16'h1234;
      foreach (addrs[i]) begin
         do_write(addrs[i], 16'($urandom) | 16'h0001);
         do_read(addrs[i], d, e);
         checks++;
         if (d !== 16'h0 || d !== e) begin errors++; $display("FAIL unmapped_%h: got %h expected 0000", addrs[i], d); end
      end
      for (int o = 0; o < 64; o++) begin
         do_read(BASE + 16'(o), d, e);
         checks++;
         if (d !== e) begin errors++; $display("FAIL sweep_off%0d: got %h expected %h", o, d, e); end
      end
      checks++;
      if (act_mismatches() != 0) begin errors++; $display("FAIL unmapped_active: %0d fields differ expected 0", act_mismatches()); end
   endtask

   task automatic test_random();
      logic [15:0] a, d, e;
      int op;
      for (int it = 0; it < 300; it++) begin
         op = $urandom_range(0, 9);
         a = rand_addr();
         if (op <= 4) begin
            do_write(a, 16'($urandom));
         end else if (op <= 6) begin
            do_read(a, d, e);
            checks++;
            if (d !== e) begin errors++; $display("FAIL rand_read@%h: got %h expected %h", a, d, e); end
         end else if (op == 7) begin
            do_rw(a, 16'($urandom), d, e);
            checks++;
            if (d !== e) begin errors++; $display("FAIL rand_rw@%h: got %h expected %h", a, d, e); end
         end else begin
            run_frame();
            checks++;
            if (act_mismatches() != 0) begin errors++; $display("FAIL rand_frame: %0d active fields differ expected 0", act_mismatches()); end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] d, e;
      do_write(BASE + 16'h01, 16'hA5A5);
      do_read(BASE + 16'h01, d, e);
      do_write(BASE + 16'h04, 16'h0001);
      @(negedge clk);
      vga_int = 1'b1;
      wait_ack(1'b1);
      #2 rst = 1'b1;
      #1;
      m_reset();
      checks += 4;
      if (vga_ack !== 1'b0) begin errors++; $display("FAIL midrst_ack: got %b expected 0", vga_ack); end
      if (act_mismatches() != 0) begin errors++; $display("FAIL midrst_active: %0d fields differ expected 0", act_mismatches()); end
      if (cpu_dout !== 16'h0 || cpu_irq !== 1'b0) begin
         errors++; $display("FAIL midrst_cpu: dout=%h irq=%b expected 0000/0", cpu_dout, cpu_irq);
      end
      if (spaceship_y !== 16'd440) begin errors++; $display("FAIL midrst_ship_y: got %0d expected 440", spaceship_y); end
      @(negedge clk);
      rst = 1'b0;
      wait_ack(1'b1);
      vga_int = 1'b0;
      wait_ack(1'b0);
      m_frame();
      do_read(BASE + 16'h05, d, e);
      checks++;
      if (d !== e || d !== 16'd1) begin errors++; $display("FAIL midrst_reservice: fcnt %0d expected 1", d); end
   endtask

   initial begin
      cpu_addr = 16'h0; cpu_din = 16'h0; cpu_we = 1'b0; cpu_re = 1'b0; vga_int = 1'b0;
      rst = 1'b1;
      m_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_no_commit();
      test_commit();
      test_service_collision();
      test_irq();
      test_unmapped();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

endmodule
